memory_scheduler: RTL and testbench
===================================

MEMORY_SCHEDULER -- requirements
Module: memory_scheduler

Interface
REQ-001 Parameter: TIMEOUT, 1023, BUSY cycles without memory_ready before a transaction is aborted with error (legal 1..65535).
REQ-002 Port: clock  in  1  single clock, all state on rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high.
REQ-004 Port: {imemory,dmemory,pmemory}_valid  in  1  per-requester request pulse (pmemory = debug/peripheral master).
REQ-005 Port: {imemory,dmemory,pmemory}_instr  in  1  request is instruction fetch.
REQ-006 Port: {imemory,dmemory,pmemory}_addr  in  32  byte address.
REQ-007 Port: {imemory,dmemory,pmemory}_wdata  in  32  write data.
REQ-008 Port: {imemory,dmemory,pmemory}_wstrb  in  4  byte strobes, 0 = read.
REQ-009 Port: {imemory,dmemory,pmemory}_rdata  out  32  read data, valid with ready.
REQ-010 Port: {imemory,dmemory,pmemory}_ready  out  1  one-cycle completion pulse.
REQ-011 Port: {imemory,dmemory,pmemory}_error  out  1  completion was a timeout abort, qualified by ready.
REQ-012 Port: memory_valid/instr/addr/wdata/wstrb  out  1/1/32/32/4  shared memory request.
REQ-013 Port: memory_rdata  in  32, memory_ready  in  1  shared memory response.

Function
REQ-014 Each requester SHALL have a pending register capturing instr/addr/wdata/wstrb on valid=1 when that port is neither pending nor in flight; valid while pending or in flight SHALL be ignored.
REQ-015 States SHALL be IDLE, BUSY, DRAIN.
REQ-016 In IDLE, the winner among pending registers plus this cycle's valid inputs SHALL be issued combinationally in the same cycle (zero-latency), state -> BUSY.
REQ-017 Arbitration SHALL be round-robin: search starts at the port after last_grant in order imemory, dmemory, pmemory, wrapping; last_grant resets to pmemory, so imemory wins first.
REQ-018 The winner's pending register SHALL clear on issue; losers keep theirs.
REQ-019 memory_valid and fields SHALL be held stable from issue until completion or abort; all memory_* outputs SHALL be 0 when no transaction is active.
REQ-020 memory_ready SHALL be honoured only in BUSY from the cycle after issue; in the issue cycle and in IDLE it SHALL be ignored.
REQ-021 On memory_ready in BUSY: owner ready=1, rdata=memory_rdata, error=0 in that cycle; state -> IDLE; the next winner MAY be issued in the same cycle (back-to-back, zero bubble).
REQ-022 Non-owner ready/rdata/error SHALL be 0 every cycle.
REQ-023 A 16-bit counter SHALL clear on issue and increment each BUSY cycle without memory_ready; at count == TIMEOUT: owner ready=1, error=1, rdata=0; memory_valid drops; state -> DRAIN.
REQ-024 In DRAIN nothing SHALL be issued; the first memory_ready SHALL be swallowed (no requester ready), state -> IDLE next cycle.
REQ-025 Simultaneous memory_ready and timeout SHALL be treated as normal completion.

Reset
REQ-026 On reset: state IDLE, all pending cleared, counter 0, last_grant=pmemory, every output 0 from the following cycle; in-flight transactions are dropped without a ready pulse.
REQ-027 reset SHALL override every other input in the same cycle.

Structure
REQ-028 State enum, port-index codes and the reg_type record SHALL be in the shared constants/wires packages.
REQ-029 The round-robin winner select SHALL be one combinational sub-module, rr_select (3 request bits + last_grant -> one-hot grant).

Verification
REQ-030 Idle, dmemory_valid addr=0x100 wstrb=0 -> memory_valid same cycle, addr 0x100; memory_ready+rdata=0xDEADBEEF 2 cycles later -> dmemory_ready=1, rdata=0xDEADBEEF, error=0.
REQ-031 All three valid in one cycle, memory answering 1 cycle after issue -> grant order imemory, dmemory, pmemory, back-to-back with no idle cycle.
REQ-032 TIMEOUT=4, memory silent -> owner ready=1, error=1 on 4th BUSY cycle; later memory_ready swallowed; next pending issues one cycle after the swallow.
REQ-033 imemory_valid re-pulsed with new addr while in flight -> ignored; only one imemory transaction observed.
REQ-034 reset in middle of BUSY with dmemory pending -> all outputs 0 next cycle, no ready pulse, stale memory_ready ignored, next request granted to imemory first.

Source files
------------

// File: rtl/memory_scheduler_pkg.sv
// Shared types and constants for the three-requester memory scheduler.
package memory_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int NUM_PORTS = 3;

  localparam logic [1:0] PORT_I = 2'd0;
  localparam logic [1:0] PORT_D = 2'd1;
  localparam logic [1:0] PORT_P = 2'd2;

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } reg_type;

endpackage

// File: rtl/memory_scheduler_rr_select.sv
// Round-robin winner select: the search begins at the port after last_grant.
module memory_scheduler_rr_select
  import memory_scheduler_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last_grant,
  output logic [2:0] grant
);

  always_comb begin
    grant = '0;
    case (last_grant)
      PORT_I: begin
        if (req[1])      grant = 3'b010;
        else if (req[2]) grant = 3'b100;
        else if (req[0]) grant = 3'b001;
      end
      PORT_D: begin
        if (req[2])      grant = 3'b100;
        else if (req[0]) grant = 3'b001;
        else if (req[1]) grant = 3'b010;
      end
      default: begin
        if (req[0])      grant = 3'b001;
        else if (req[1]) grant = 3'b010;
        else if (req[2]) grant = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/memory_scheduler.sv
// Arbitrates imemory/dmemory/pmemory onto one shared memory port with
// zero-latency issue, back-to-back completion and a timeout abort.
module memory_scheduler
  import memory_scheduler_pkg::*;
#(
  parameter int TIMEOUT = 1023
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        imemory_valid,
  input  logic        imemory_instr,
  input  logic [31:0] imemory_addr,
  input  logic [31:0] imemory_wdata,
  input  logic [3:0]  imemory_wstrb,
  output logic [31:0] imemory_rdata,
  output logic        imemory_ready,
  output logic        imemory_error,
  input  logic        dmemory_valid,
  input  logic        dmemory_instr,
  input  logic [31:0] dmemory_addr,
  input  logic [31:0] dmemory_wdata,
  input  logic [3:0]  dmemory_wstrb,
  output logic [31:0] dmemory_rdata,
  output logic        dmemory_ready,
  output logic        dmemory_error,
  input  logic        pmemory_valid,
  input  logic        pmemory_instr,
  input  logic [31:0] pmemory_addr,
  input  logic [31:0] pmemory_wdata,
  input  logic [3:0]  pmemory_wstrb,
  output logic [31:0] pmemory_rdata,
  output logic        pmemory_ready,
  output logic        pmemory_error,
  output logic        memory_valid,
  output logic        memory_instr,
  output logic [31:0] memory_addr,
  output logic [31:0] memory_wdata,
  output logic [3:0]  memory_wstrb,
  input  logic [31:0] memory_rdata,
  input  logic        memory_ready
);

  localparam logic [16:0] TIMEOUT_CNT = 17'(TIMEOUT);

  state_t      state, state_next;
  logic [15:0] count;
  logic [1:0]  last_grant, owner, win_idx;
  logic [2:0]  pend_v, in_valid, in_flight, capture, req_bits, grant;
  logic [2:0]  ready_v, error_v;
  reg_type     pend_req [NUM_PORTS];
  reg_type     in_req   [NUM_PORTS];
  reg_type     cand     [NUM_PORTS];
  reg_type     cur, mem_req;
  logic [31:0] rdata_v  [NUM_PORTS];
  logic        complete, abort, count_hit, can_issue, issue, mem_valid;

  assign in_valid = {pmemory_valid, dmemory_valid, imemory_valid};
  assign in_req[PORT_I] = '{instr: imemory_instr, addr: imemory_addr, wdata: imemory_wdata, wstrb: imemory_wstrb};
  assign in_req[PORT_D] = '{instr: dmemory_instr, addr: dmemory_addr, wdata: dmemory_wdata, wstrb: dmemory_wstrb};
  assign in_req[PORT_P] = '{instr: pmemory_instr, addr: pmemory_addr, wdata: pmemory_wdata, wstrb: pmemory_wstrb};

  // A port competes with its pending request, or with a fresh pulse when it is free.
  always_comb begin
    in_flight = '0;
    capture   = '0;
    req_bits  = '0;
    cand      = in_req;
    for (int i = 0; i < NUM_PORTS; i++) begin
      in_flight[i] = (state == BUSY) && (owner == 2'(i));
      capture[i]   = in_valid[i] && !pend_v[i] && !in_flight[i];
      req_bits[i]  = pend_v[i] || capture[i];
      if (pend_v[i]) cand[i] = pend_req[i];
    end
  end

  memory_scheduler_rr_select u_rr_select (
    .req        (req_bits),
    .last_grant (last_grant),
    .grant      (grant)
  );

  always_comb begin
    win_idx = PORT_I;
    if (grant[1]) win_idx = PORT_D;
    if (grant[2]) win_idx = PORT_P;
  end

  // Completion beats a timeout that lands in the same cycle.
  assign count_hit = ({1'b0, count} + 17'd1) == TIMEOUT_CNT;
  assign complete  = !reset && (state == BUSY) && memory_ready;
  assign abort     = !reset && (state == BUSY) && !memory_ready && count_hit;
  assign can_issue = !reset && ((state == IDLE) || complete);
  assign issue     = can_issue && (|req_bits);

  always_comb begin
    state_next = state;
    mem_valid  = 1'b0;
    mem_req    = '0;
    case (state)
      IDLE:    if (issue) state_next = BUSY;
      BUSY: begin
        if (complete)   state_next = issue ? BUSY : IDLE;
        else if (abort) state_next = DRAIN;
      end
      DRAIN:   if (memory_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (issue) begin
      mem_valid = 1'b1;
      mem_req   = cand[win_idx];
    end else if (!reset && (state == BUSY) && !abort) begin
      mem_valid = 1'b1;
      mem_req   = cur;
    end
  end

  always_comb begin
    ready_v = '0;
    error_v = '0;
    rdata_v = '{default: '0};
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (owner == 2'(i)) begin
        ready_v[i] = complete || abort;
        error_v[i] = abort;
        if (complete) rdata_v[i] = memory_rdata;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count      <= '0;
      last_grant <= PORT_P;
      owner      <= PORT_I;
      pend_v     <= '0;
      cur        <= '0;
      for (int i = 0; i < NUM_PORTS; i++) pend_req[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (issue && grant[i]) begin
          pend_v[i] <= 1'b0;
        end else if (capture[i]) begin
          pend_v[i]   <= 1'b1;
          pend_req[i] <= in_req[i];
        end
      end
      if (issue) begin
        owner      <= win_idx;
        last_grant <= win_idx;
        cur        <= cand[win_idx];
        count      <= '0;
      end else if ((state == BUSY) && !memory_ready) begin
        count <= count + 16'd1;
      end
    end
  end

  assign memory_valid  = mem_valid;
  assign memory_instr  = mem_req.instr;
  assign memory_addr   = mem_req.addr;
  assign memory_wdata  = mem_req.wdata;
  assign memory_wstrb  = mem_req.wstrb;

  assign imemory_ready = ready_v[0];
  assign dmemory_ready = ready_v[1];
  assign pmemory_ready = ready_v[2];
  assign imemory_error = error_v[0];
  assign dmemory_error = error_v[1];
  assign pmemory_error = error_v[2];
  assign imemory_rdata = rdata_v[0];
  assign dmemory_rdata = rdata_v[1];
  assign pmemory_rdata = rdata_v[2];

endmodule

// File: tb/tb_memory_scheduler.sv
// Directed bench for memory_scheduler: expected completions go into a
// scoreboard queue that a negedge monitor drains as requesters see ready.
module tb_memory_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        imemory_valid, imemory_instr, dmemory_valid, dmemory_instr, pmemory_valid, pmemory_instr;
  logic [31:0] imemory_addr, imemory_wdata, dmemory_addr, dmemory_wdata, pmemory_addr, pmemory_wdata;
  logic [3:0]  imemory_wstrb, dmemory_wstrb, pmemory_wstrb;
  logic [31:0] imemory_rdata, dmemory_rdata, pmemory_rdata;
  logic        imemory_ready, dmemory_ready, pmemory_ready;
  logic        imemory_error, dmemory_error, pmemory_error;
  logic        memory_valid, memory_instr, memory_ready;
  logic [31:0] memory_addr, memory_wdata, memory_rdata;
  logic [3:0]  memory_wstrb;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb [$];
  exp_t        popped;
  int          n_vectors = 0;
  int          n_miscompares = 0;
  logic [2:0]  rdy, er;
  logic [31:0] rd [3];

  assign rdy   = {pmemory_ready, dmemory_ready, imemory_ready};
  assign er    = {pmemory_error, dmemory_error, imemory_error};
  assign rd[0] = imemory_rdata;
  assign rd[1] = dmemory_rdata;
  assign rd[2] = pmemory_rdata;

  memory_scheduler #(.TIMEOUT(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .imemory_valid (imemory_valid),
    .imemory_instr (imemory_instr),
    .imemory_addr  (imemory_addr),
    .imemory_wdata (imemory_wdata),
    .imemory_wstrb (imemory_wstrb),
    .imemory_rdata (imemory_rdata),
    .imemory_ready (imemory_ready),
    .imemory_error (imemory_error),
    .dmemory_valid (dmemory_valid),
    .dmemory_instr (dmemory_instr),
    .dmemory_addr  (dmemory_addr),
    .dmemory_wdata (dmemory_wdata),
    .dmemory_wstrb (dmemory_wstrb),
    .dmemory_rdata (dmemory_rdata),
    .dmemory_ready (dmemory_ready),
    .dmemory_error (dmemory_error),
    .pmemory_valid (pmemory_valid),
    .pmemory_instr (pmemory_instr),
    .pmemory_addr  (pmemory_addr),
    .pmemory_wdata (pmemory_wdata),
    .pmemory_wstrb (pmemory_wstrb),
    .pmemory_rdata (pmemory_rdata),
    .pmemory_ready (pmemory_ready),
    .pmemory_error (pmemory_error),
    .memory_valid  (memory_valid),
    .memory_instr  (memory_instr),
    .memory_addr   (memory_addr),
    .memory_wdata  (memory_wdata),
    .memory_wstrb  (memory_wstrb),
    .memory_rdata  (memory_rdata),
    .memory_ready  (memory_ready)
  );

  initial forever #5 clock = ~clock;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vectors++;
    if (act !== req) begin
      n_miscompares++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_requests();
    imemory_valid = 0; imemory_instr = 0; imemory_addr = 0; imemory_wdata = 0; imemory_wstrb = 0;
    dmemory_valid = 0; dmemory_instr = 0; dmemory_addr = 0; dmemory_wdata = 0; dmemory_wstrb = 0;
    pmemory_valid = 0; pmemory_instr = 0; pmemory_addr = 0; pmemory_wdata = 0; pmemory_wstrb = 0;
  endtask

  task automatic apply_stimulus(input int port, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] wstrb, input logic instr);
    case (port)
      0: begin imemory_valid = 1; imemory_addr = addr; imemory_wdata = wdata; imemory_wstrb = wstrb; imemory_instr = instr; end
      1: begin dmemory_valid = 1; dmemory_addr = addr; dmemory_wdata = wdata; dmemory_wstrb = wstrb; dmemory_instr = instr; end
      default: begin pmemory_valid = 1; pmemory_addr = addr; pmemory_wdata = wdata; pmemory_wstrb = wstrb; pmemory_instr = instr; end
    endcase
  endtask

  task automatic expect_response(input int port, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.port  = port;
    e.rdata = rdata;
    e.err   = err;
    sb.push_back(e);
  endtask

  task automatic drive_memory(input logic ready, input logic [31:0] rdata);
    memory_ready = ready;
    memory_rdata = rdata;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset = 1;
    clear_requests();
    drive_memory(0, 0);
    tick();
    reset = 0;
  endtask

  // Every requester completion must match the oldest outstanding expectation.
  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (rdy[i]) begin
        if (sb.size() == 0) begin
          n_vectors++;
          n_miscompares++;
          $display("[TB] FAIL unexpected_ready port=%0d actual=1 required=0", i);
        end else begin
          popped = sb.pop_front();
          check_output("resp_port", 32'(i), 32'(popped.port));
          check_output("resp_rdata", rd[i], popped.rdata);
          check_output("resp_error", 32'(er[i]), 32'(popped.err));
        end
      end else begin
        check_output($sformatf("quiet_rdata_p%0d", i), rd[i], 32'h0);
        check_output($sformatf("quiet_error_p%0d", i), 32'(er[i]), 32'h0);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1;
    clear_requests();
    drive_memory(0, 0);
    do_reset();

    // Reset state
    @(negedge clock);
    check_output("reset_memory_valid", 32'(memory_valid), 0);
    check_output("reset_ready_vec", 32'(rdy), 0);

    // Single dmemory read answered two cycles after issue
    tick();
    apply_stimulus(1, 32'h100, 32'h0, 4'h0, 1'b0);
    expect_response(1, 32'hDEADBEEF, 1'b0);
    @(negedge clock);
    check_output("t1_issue_valid", 32'(memory_valid), 1);
    check_output("t1_issue_addr", memory_addr, 32'h100);
    check_output("t1_issue_wstrb", 32'(memory_wstrb), 0);
    tick();
    clear_requests();
    @(negedge clock);
    check_output("t1_hold_valid", 32'(memory_valid), 1);
    check_output("t1_hold_addr", memory_addr, 32'h100);
    check_output("t1_early_ready", 32'(dmemory_ready), 0);
    tick();
    drive_memory(1, 32'hDEADBEEF);
    @(negedge clock);
    check_output("t1_ready", 32'(dmemory_ready), 1);
    tick();
    drive_memory(0, 0);
    @(negedge clock);
    check_output("t1_idle_valid", 32'(memory_valid), 0);

    // Three simultaneous requests, round-robin back-to-back
    do_reset();
    apply_stimulus(0, 32'h1000, 32'h0000000A, 4'h0, 1'b1);
    apply_stimulus(1, 32'h2000, 32'h0, 4'h0, 1'b0);
    apply_stimulus(2, 32'h3000, 32'hCAFE0003, 4'hF, 1'b0);
    expect_response(0, 32'h11111111, 1'b0);
    @(negedge clock);
    check_output("t2_first_addr", memory_addr, 32'h1000);
    check_output("t2_first_instr", 32'(memory_instr), 1);
    tick();
    clear_requests();
    drive_memory(1, 32'h11111111);
    expect_response(1, 32'h22222222, 1'b0);
    @(negedge clock);
    check_output("t2_second_valid", 32'(memory_valid), 1);
    check_output("t2_second_addr", memory_addr, 32'h2000);
    check_output("t2_first_done", 32'(imemory_ready), 1);
    tick();
    drive_memory(1, 32'h22222222);
    expect_response(2, 32'h33333333, 1'b0);
    @(negedge clock);
    check_output("t2_third_addr", memory_addr, 32'h3000);
    check_output("t2_third_wstrb", 32'(memory_wstrb), 32'hF);
    check_output("t2_third_wdata", memory_wdata, 32'hCAFE0003);
    tick();
    drive_memory(1, 32'h33333333);
    @(negedge clock);
    check_output("t2_third_done", 32'(pmemory_ready), 1);
    tick();
    drive_memory(0, 0);
    @(negedge clock);
    check_output("t2_idle_valid", 32'(memory_valid), 0);

    // Timeout abort, drain swallow, then pending dmemory issues
    do_reset();
    apply_stimulus(0, 32'h40, 32'h0, 4'h0, 1'b0);
    apply_stimulus(1, 32'h80, 32'h0, 4'h0, 1'b0);
    expect_response(0, 32'h0, 1'b1);
    @(negedge clock);
    check_output("t3_issue_addr", memory_addr, 32'h40);
    tick();
    clear_requests();
    tick();
    tick();
    @(negedge clock);
    check_output("t3_busy3_ready", 32'(imemory_ready), 0);
    check_output("t3_busy3_valid", 32'(memory_valid), 1);
    tick();
    @(negedge clock);
    check_output("t3_abort_ready", 32'(imemory_ready), 1);
    check_output("t3_abort_error", 32'(imemory_error), 1);
    check_output("t3_abort_valid", 32'(memory_valid), 0);
    tick();
    @(negedge clock);
    check_output("t3_drain_valid", 32'(memory_valid), 0);
    tick();
    drive_memory(1, 32'hBAD0BAD0);
    @(negedge clock);
    check_output("t3_swallow_valid", 32'(memory_valid), 0);
    check_output("t3_swallow_dready", 32'(dmemory_ready), 0);
    tick();
    drive_memory(0, 0);
    expect_response(1, 32'hCAFEF00D, 1'b0);
    @(negedge clock);
    check_output("t3_next_valid", 32'(memory_valid), 1);
    check_output("t3_next_addr", memory_addr, 32'h80);
    tick();
    drive_memory(1, 32'hCAFEF00D);
    tick();
    drive_memory(0, 0);

    // Re-pulse while in flight is ignored
    do_reset();
    apply_stimulus(0, 32'h500, 32'h0, 4'h0, 1'b1);
    expect_response(0, 32'h55555555, 1'b0);
    @(negedge clock);
    check_output("t4_issue_addr", memory_addr, 32'h500);
    tick();
    apply_stimulus(0, 32'h600, 32'h0, 4'h0, 1'b1);
    @(negedge clock);
    check_output("t4_hold_addr", memory_addr, 32'h500);
    tick();
    clear_requests();
    drive_memory(1, 32'h55555555);
    @(negedge clock);
    check_output("t4_done_addr", memory_addr, 32'h500);
    tick();
    drive_memory(0, 0);
    @(negedge clock);
    check_output("t4_idle_valid", 32'(memory_valid), 0);

    // Reset during BUSY with dmemory pending
    do_reset();
    apply_stimulus(0, 32'h700, 32'h0, 4'h0, 1'b0);
    apply_stimulus(1, 32'h800, 32'h0, 4'h0, 1'b0);
    @(negedge clock);
    check_output("t5_issue_addr", memory_addr, 32'h700);
    tick();
    clear_requests();
    reset = 1;
    tick();
    reset = 0;
    drive_memory(1, 32'h5A5A5A5A);
    @(negedge clock);
    check_output("t5_after_reset_valid", 32'(memory_valid), 0);
    check_output("t5_after_reset_ready", 32'(rdy), 0);
    tick();
    drive_memory(0, 0);
    apply_stimulus(0, 32'h900, 32'h0, 4'h0, 1'b0);
    apply_stimulus(1, 32'hA00, 32'h0, 4'h0, 1'b0);
    expect_response(0, 32'h99999999, 1'b0);
    @(negedge clock);
    check_output("t5_first_grant_addr", memory_addr, 32'h900);
    tick();
    clear_requests();
    drive_memory(1, 32'h99999999);
    expect_response(1, 32'hAAAAAAAA, 1'b0);
    @(negedge clock);
    check_output("t5_second_addr", memory_addr, 32'hA00);
    tick();
    drive_memory(1, 32'hAAAAAAAA);
    tick();
    drive_memory(0, 0);
    @(negedge clock);
    check_output("t5_idle_valid", 32'(memory_valid), 0);

    tick();
    tick();
    check_output("scoreboard_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
